// File: rtl/if_id_fetch_buffer.sv
// +---------------------------------------------------------------------------+
// | Module      : if_id_fetch_buffer                                          |
// | Description : IF/ID boundary queue holding fetched {pc, instr} pairs and  |
// |               presenting the oldest to decode; optional IF_ID_STATS_EN    |
// |               adds saturating stall/flush counters.                       |
// | Revision    : 1.0 - initial release                                       |
// +---------------------------------------------------------------------------+
`default_nettype none

module if_id_fetch_buffer #(
  parameter int          DEPTH     = 2,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_i,
  input  logic [31:0] instr_i,
  input  logic        fetch_valid_i,
  output logic        fetch_ready_o,
  input  logic        flush_i,
  output logic        id_valid_o,
  input  logic        id_ready_i,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_pc_plus4_o,
  output logic [31:0] id_instr_o
`ifdef IF_ID_STATS_EN
  ,
  output logic [15:0] stall_cnt_o,
  output logic [15:0] flush_cnt_o
`endif
);

  localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_cnt_w = $clog2(DEPTH + 1);
  localparam logic [c_ptr_w-1:0] c_ptr_last = c_ptr_w'(DEPTH - 1);
  localparam logic [c_cnt_w-1:0] c_depth    = c_cnt_w'(DEPTH);

  logic [31:0]        r_pc_mem    [DEPTH];
  logic [31:0]        r_instr_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_cnt_w-1:0] r_count;

  logic               w_push;
  logic               w_pop;
  logic [c_ptr_w-1:0] w_wr_ptr_nxt;
  logic [c_ptr_w-1:0] w_rd_ptr_nxt;

  // Ready depends only on stored occupancy, so a full queue refuses a push
  // even when decode drains an entry in the same cycle.
  assign fetch_ready_o = (r_count < c_depth);
  assign id_valid_o    = (r_count != '0);
  assign w_push        = fetch_valid_i & fetch_ready_o;
  assign w_pop         = id_valid_o & id_ready_i;

  assign w_wr_ptr_nxt = (r_wr_ptr == c_ptr_last) ? '0 : r_wr_ptr + 1'b1;
  assign w_rd_ptr_nxt = (r_rd_ptr == c_ptr_last) ? '0 : r_rd_ptr + 1'b1;

  assign id_pc_o       = id_valid_o ? r_pc_mem[r_rd_ptr]    : 32'h0;
  assign id_instr_o    = id_valid_o ? r_instr_mem[r_rd_ptr] : NOP_INSTR;
  assign id_pc_plus4_o = id_pc_o + 32'd4;

  // Payload storage is not reset; entries are only read once marked valid.
  always_ff @(posedge clk) begin
    if (w_push && !flush_i && !rst) begin
      r_pc_mem[r_wr_ptr]    <= pc_i;
      r_instr_mem[r_wr_ptr] <= instr_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush_i) begin
      r_rd_ptr <= r_wr_ptr;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= w_wr_ptr_nxt;
      if (w_pop)  r_rd_ptr <= w_rd_ptr_nxt;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef IF_ID_STATS_EN
  logic [15:0] r_stall_cnt;
  logic [15:0] r_flush_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (fetch_valid_i && !fetch_ready_o && (r_stall_cnt != 16'hFFFF))
        r_stall_cnt <= r_stall_cnt + 16'd1;
      if (flush_i && id_valid_o && (r_flush_cnt != 16'hFFFF))
        r_flush_cnt <= r_flush_cnt + 16'd1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
  assign flush_cnt_o = r_flush_cnt;
`endif

endmodule

`default_nettype wire
